// File: rtl/plotter_pkg.sv
// Shared definitions for the plotter motion controller and the servo PWM block.
package plotter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PEN     = 3'd1,
    ST_STEP_HI = 3'd2,
    ST_STEP_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic PEN_UP   = 1'b0;
  localparam logic PEN_DOWN = 1'b1;

  localparam logic [31:0] DEFAULT_DUTY_UP   = 32'd100000;
  localparam logic [31:0] DEFAULT_DUTY_DOWN = 32'd200000;

endpackage

// File: rtl/plotter_motion_ctrl_timer.sv
// Loadable 32-bit down-counter that holds at zero; shared by the settle and step waits.
module motion_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic        zero_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 32'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != 32'd0) begin
      count_q <= count_q - 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign zero_o = (count_q == 32'd0);

endmodule

// File: rtl/plotter_motion_ctrl.sv
// Single-axis move sequencer: optional pen change with servo settle, then N timed step pulses.
module plotter_motion_ctrl
  import plotter_pkg::*;
#(
  parameter int unsigned STEP_PERIOD  = 50000,
  parameter int unsigned STEP_HIGH    = 500,
  parameter int unsigned SERVO_SETTLE = 5000000,
  parameter logic [31:0] DUTY_UP      = DEFAULT_DUTY_UP,
  parameter logic [31:0] DUTY_DOWN    = DEFAULT_DUTY_DOWN,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_pen,
  output logic             step_out,
  output logic             dir_out,
  output logic [31:0]      servo_duty,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam logic [31:0] HI_LOAD  = 32'(STEP_HIGH - 1);
  localparam logic [31:0] LO_LOAD  = 32'(STEP_PERIOD - STEP_HIGH - 1);
  localparam logic [31:0] PEN_LOAD = 32'(SERVO_SETTLE - 1);

  state_e           state_q;
  logic             step_q, dir_q, pen_q, busy_q, done_q;
  logic [CNT_W-1:0] steps_left_q;
  logic             accept_s, tmr_zero_s, tmr_load_s;
  logic [31:0]      tmr_val_s;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign accept_s   = cmd_valid & cmd_ready;
  assign servo_duty = (pen_q == PEN_DOWN) ? DUTY_DOWN : DUTY_UP;
  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_left_q;

  motion_timer u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .zero_o     (tmr_zero_s)
  );

  // Timer reloads must line up with the FSM transitions below
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (cmd_pen != pen_q)) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = PEN_LOAD;
        end else if (accept_s && (cmd_steps != '0)) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HI_LOAD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_PEN: begin
        if (tmr_zero_s && (steps_left_q != '0)) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HI_LOAD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_STEP_HI: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = LO_LOAD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_STEP_LO: begin
        if (tmr_zero_s && (steps_left_q != CNT_W'(1))) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HI_LOAD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      default: tmr_load_s = 1'b0;
    endcase
  end

  // Move sequencer with registered step/busy/done outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      pen_q        <= PEN_UP;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            steps_left_q <= cmd_steps;
            dir_q        <= cmd_dir;
            pen_q        <= cmd_pen;
            busy_q       <= 1'b1;
            if (cmd_pen != pen_q) begin
              state_q <= ST_PEN;
            end else if (cmd_steps == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_STEP_HI;
              step_q  <= 1'b1;
            end
          end
        end
        ST_PEN: begin
          if (tmr_zero_s && (steps_left_q == '0)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (tmr_zero_s) begin
            state_q <= ST_STEP_HI;
            step_q  <= 1'b1;
          end
        end
        ST_STEP_HI: begin
          if (tmr_zero_s) begin
            state_q <= ST_STEP_LO;
            step_q  <= 1'b0;
          end
        end
        ST_STEP_LO: begin
          if (tmr_zero_s) begin
            steps_left_q <= steps_left_q - CNT_W'(1);
            if (steps_left_q == CNT_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_STEP_HI;
              step_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plotter_motion_ctrl.sv
// Directed bench for plotter_motion_ctrl with STEP_PERIOD=10, STEP_HIGH=3, SERVO_SETTLE=20.
module tb_plotter_motion_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_dir, cmd_pen;
  logic [15:0] cmd_steps;
  logic        step_out, dir_out, busy, done;
  logic [31:0] servo_duty;
  logic [15:0] steps_left;

  int compared = 0;
  int failed   = 0;

  logic        st_tr [0:63];
  logic        dn_tr [0:63];
  logic        rd_tr [0:63];
  logic        dir_tr[0:63];
  logic        bz_tr [0:63];
  logic [15:0] sl_tr [0:63];
  logic [31:0] du_tr [0:63];

  plotter_motion_ctrl #(
    .STEP_PERIOD (10),
    .STEP_HIGH   (3),
    .SERVO_SETTLE(20),
    .DUTY_UP     (32'd100000),
    .DUTY_DOWN   (32'd200000),
    .CNT_W       (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_pen   (cmd_pen),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .servo_duty(servo_duty),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic record(input int i);
    st_tr[i]  = step_out;
    dn_tr[i]  = done;
    rd_tr[i]  = cmd_ready;
    dir_tr[i] = dir_out;
    bz_tr[i]  = busy;
    sl_tr[i]  = steps_left;
    du_tr[i]  = servo_duty;
  endtask

  // Called at a negedge; drives a command.
  task automatic issue(input logic [15:0] s, input logic d, input logic p);
    cmd_steps = s;
    cmd_dir   = d;
    cmd_pen   = p;
    cmd_valid = 1'b1;
  endtask

  // Index 0 is the cycle carrying the accept edge; index i is sampled i edges later.
  task automatic observe(input int n, input int chg_at, input int drop_at,
                         input logic [15:0] s2, input logic d2);
    record(0);
    @(posedge clock);
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      record(i);
      if (i == chg_at) begin
        cmd_steps = s2;
        cmd_dir   = d2;
      end
      if (i == drop_at) cmd_valid = 1'b0;
    end
  endtask

  function automatic int exp_st(input int i, input int off, input int n);
    return (i > off && i <= off + n * 10 && ((i - off - 1) % 10) < 3) ? 1 : 0;
  endfunction

  function automatic int step_mism(input int n, input int o1, input int n1, input int o2, input int n2);
    int m = 0;
    for (int i = 1; i <= n; i++)
      if (st_tr[i] !== 1'((exp_st(i, o1, n1) | exp_st(i, o2, n2)) != 0)) m++;
    return m;
  endfunction

  function automatic int rises(input int n);
    int r = 0;
    for (int i = 1; i <= n; i++) if (st_tr[i] === 1'b1 && st_tr[i-1] !== 1'b1) r++;
    return r;
  endfunction

  function automatic int first_done(input int n);
    for (int i = 1; i <= n; i++) if (dn_tr[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int done_cnt(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (dn_tr[i] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    int bad;
    int highs;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = 16'd0;
    cmd_dir   = 1'b0;
    cmd_pen   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("rst_step", 32'(step_out), 32'd0);
    chk("rst_dir", 32'(dir_out), 32'd0);
    chk("rst_duty", servo_duty, 32'd100000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_steps_left", 32'(steps_left), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 4 steps, dir 1, pen stays up
    issue(16'd4, 1'b1, 1'b0);
    observe(45, 0, 1, 16'd0, 1'b0);
    chk("m1_pattern", 32'(step_mism(45, 0, 4, 0, 0)), 32'd0);
    chk("m1_pulses", 32'(rises(45)), 32'd4);
    chk("m1_done_cycle", 32'(first_done(45)), 32'd41);
    chk("m1_done_count", 32'(done_cnt(45)), 32'd1);
    bad = 0;
    for (int i = 1; i <= 41; i++) if (dir_tr[i] !== 1'b1) bad++;
    chk("m1_dir_held", 32'(bad), 32'd0);
    chk("m1_sl_c1", 32'(sl_tr[1]), 32'd4);
    chk("m1_sl_c11", 32'(sl_tr[11]), 32'd3);
    chk("m1_sl_c21", 32'(sl_tr[21]), 32'd2);
    chk("m1_sl_c31", 32'(sl_tr[31]), 32'd1);
    chk("m1_sl_c41", 32'(sl_tr[41]), 32'd0);
    chk("m1_ready_in_done", 32'(rd_tr[41]), 32'd0);
    chk("m1_busy_in_done", 32'(bz_tr[41]), 32'd1);
    chk("m1_ready_after", 32'(rd_tr[42]), 32'd1);

    // 2 steps, pen goes down: 20-cycle settle first
    issue(16'd2, 1'b0, 1'b1);
    observe(45, 0, 1, 16'd0, 1'b0);
    chk("m2_duty_before", du_tr[0], 32'd100000);
    chk("m2_duty_next", du_tr[1], 32'd200000);
    chk("m2_pattern", 32'(step_mism(45, 20, 2, 0, 0)), 32'd0);
    chk("m2_pulses", 32'(rises(45)), 32'd2);
    chk("m2_done_cycle", 32'(first_done(45)), 32'd41);
    chk("m2_dir", 32'(dir_tr[25]), 32'd0);

    // Zero-step move, pen unchanged
    issue(16'd0, 1'b1, 1'b1);
    observe(5, 0, 1, 16'd0, 1'b0);
    chk("m3_done_cycle", 32'(first_done(5)), 32'd1);
    chk("m3_done_count", 32'(done_cnt(5)), 32'd1);
    chk("m3_pulses", 32'(rises(5)), 32'd0);
    bad = 0;
    for (int i = 1; i <= 5; i++) if (rd_tr[i] !== 1'b1) bad++;
    chk("m3_ready_low_cycles", 32'(bad), 32'd1);

    // cmd_valid held with new values mid-move; second command waits for done
    issue(16'd1, 1'b1, 1'b1);
    observe(50, 5, 13, 16'd3, 1'b0);
    chk("m4_done_first", 32'(first_done(50)), 32'd11);
    chk("m4_done_count", 32'(done_cnt(50)), 32'd2);
    chk("m4_done_second", 32'(dn_tr[43]), 32'd1);
    chk("m4_sl_ignored", 32'(sl_tr[8]), 32'd1);
    chk("m4_dir_ignored", 32'(dir_tr[10]), 32'd1);
    chk("m4_ready_gap", 32'(rd_tr[12]), 32'd1);
    chk("m4_second_sl", 32'(sl_tr[13]), 32'd3);
    chk("m4_second_dir", 32'(dir_tr[13]), 32'd0);
    chk("m4_pattern", 32'(step_mism(50, 0, 1, 12, 3)), 32'd0);
    chk("m4_pulses", 32'(rises(50)), 32'd4);

    // Raise pen with a zero-step move, then reset during 2nd pulse of a pen-down move
    issue(16'd0, 1'b0, 1'b0);
    observe(25, 0, 1, 16'd0, 1'b0);
    chk("m5_done_cycle", 32'(first_done(25)), 32'd21);
    chk("m5_pulses", 32'(rises(25)), 32'd0);
    chk("m5_duty_up", du_tr[1], 32'd100000);

    issue(16'd3, 1'b1, 1'b1);
    observe(31, 0, 1, 16'd0, 1'b0);
    chk("m6_second_rise", 32'(st_tr[31] & ~st_tr[30]), 32'd1);
    chk("m6_duty_down", du_tr[31], 32'd200000);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_step", 32'(step_out), 32'd0);
    chk("rst_mid_duty", servo_duty, 32'd100000);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_sl", 32'(steps_left), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (step_out !== 1'b0) highs++;
    end
    chk("post_rst_no_pulses", 32'(highs), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
